// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit FCS controller state type.
package eth_pkg;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam int          ETH_MIN_FRAME = 60;

    typedef enum logic [1:0] {FT_PASS, FT_PAD, FT_FCS} fcs_tx_state_t;

endpackage

// File: rtl/crc32_8bit.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32 (LSB first).
module crc32_8bit
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        crc_out = c;
    end

endmodule

// File: rtl/eth_fcs_tx_ctrl.sv
// Transmit frame finisher: passes payload, zero-pads to the minimum length
// and appends the 4-byte FCS, least significant byte first.
module eth_fcs_tx_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
    parameter int CNT_W           = (MIN_FRAME_BYTES < 1) ? 1 : $clog2(MIN_FRAME_BYTES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] fcs_value,
    output logic        frame_done
);

    fcs_tx_state_t    state, state_nxt;
    logic [31:0]      crc, crc_nxt;
    logic [CNT_W-1:0] byte_cnt, cnt_nxt, cnt_sat;
    logic [1:0]       idx, idx_nxt;
    logic [7:0]       out_data_nxt;
    logic             out_valid_nxt, out_last_nxt, frame_done_nxt;
    logic [31:0]      fcs_nxt, fcs_word, crc_step;
    logic [7:0]       crc_din;
    logic             load_en, short_frame, pad_done;

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (state == FT_PASS) && load_en;
    assign crc_din  = (state == FT_PAD) ? 8'h00 : in_data;
    assign fcs_word = ~crc;

    crc32_8bit u_crc (
        .crc_in  (crc),
        .data    (crc_din),
        .crc_out (crc_step)
    );

    // Counter saturates at the minimum, so long frames never wrap it.
    always_comb begin
        cnt_sat = byte_cnt;
        if (int'(byte_cnt) < MIN_FRAME_BYTES)
            cnt_sat = byte_cnt + CNT_W'(1);
    end

    assign short_frame = (int'(byte_cnt) + 1) <  MIN_FRAME_BYTES;
    assign pad_done    = (int'(byte_cnt) + 1) == MIN_FRAME_BYTES;

    always_comb begin
        state_nxt      = state;
        crc_nxt        = crc;
        cnt_nxt        = byte_cnt;
        idx_nxt        = idx;
        out_data_nxt   = out_data;
        out_valid_nxt  = out_valid;
        out_last_nxt   = out_last;
        fcs_nxt        = fcs_value;
        frame_done_nxt = out_valid && out_ready && out_last;

        case (state)
            FT_PASS: begin
                if (load_en) begin
                    if (in_valid) begin
                        out_data_nxt  = in_data;
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = 1'b0;
                        crc_nxt       = crc_step;
                        cnt_nxt       = cnt_sat;
                        if (in_last) begin
                            if (short_frame) begin
                                state_nxt = FT_PAD;
                            end else begin
                                state_nxt = FT_FCS;
                                idx_nxt   = 2'd0;
                            end
                        end
                    end else begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                    end
                end
            end
            FT_PAD: begin
                if (load_en) begin
                    out_data_nxt  = 8'h00;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    crc_nxt       = crc_step;
                    cnt_nxt       = cnt_sat;
                    if (pad_done) begin
                        state_nxt = FT_FCS;
                        idx_nxt   = 2'd0;
                    end
                end
            end
            FT_FCS: begin
                // crc is frozen here; idx walks the complemented word LSB first.
                if (load_en) begin
                    out_data_nxt  = fcs_word[{idx, 3'b000} +: 8];
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    idx_nxt       = idx + 2'd1;
                    if (idx == 2'd3) begin
                        out_last_nxt = 1'b1;
                        fcs_nxt      = fcs_word;
                        state_nxt    = FT_PASS;
                        crc_nxt      = CRC32_INIT;
                        cnt_nxt      = '0;
                    end
                end
            end
            default: state_nxt = FT_PASS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FT_PASS;
            crc        <= CRC32_INIT;
            byte_cnt   <= '0;
            idx        <= 2'd0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            fcs_value  <= 32'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            crc        <= crc_nxt;
            byte_cnt   <= cnt_nxt;
            idx        <= idx_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_last   <= out_last_nxt;
            fcs_value  <= fcs_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: doc/eth_fcs_tx_ctrl.md
Name: eth_fcs_tx_ctrl

Overview:
Transmit-side Ethernet frame finisher. It sits between the MAC payload source and the byte-wide PHY transmit path. For each frame it sequences the shared byte-wise CRC-32 step, zero-pads short frames to the minimum length, and appends the 4-byte FCS. It owns the CRC register, pad counter and byte-stream handshake; the CRC step itself is combinational.

Parameters:
MIN_FRAME_BYTES, 60, minimum pre-FCS length (dst..payload); shorter frames are zero-padded; 0 disables padding
CNT_W, $clog2(MIN_FRAME_BYTES+1) (min 1), width of the saturating byte counter

Ports:
clk  input  1  sole clock
reset  input  1  asynchronous, active-high reset
in_data  input  8  frame byte, bit 0 first on the wire
in_valid  input  1  in_data valid
in_last  input  1  final payload byte of frame (qualified by in_valid)
in_ready  output  1  controller accepts the input byte this cycle
out_data  output  8  payload, pad or FCS byte
out_valid  output  1  out_data valid
out_last  output  1  final FCS byte of frame
out_ready  input  1  downstream accepts the output byte this cycle
fcs_value  output  32  FCS of the most recent completed frame (~crc), held until the next frame completes
frame_done  output  1  one-cycle pulse when the last FCS byte is accepted downstream

Behaviour:
- Reset (async): state=PASS, crc=32'hFFFFFFFF, byte_cnt=0, out_valid=0, out_data=0, out_last=0, fcs_value=0, frame_done=0. Reset mid-frame discards the frame. No partial FCS is emitted.
- Output register: loads when load_en = !out_valid || out_ready. Otherwise it holds all out_* signals stable. A transfer occurs on out_valid && out_ready.
- in_ready = (state==PASS) && load_en. Input-to-output latency is 1 cycle. Back-to-back throughput is 1 byte/cycle.
- States:
  - PASS: on in_valid && in_ready:
    - out_data<=in_data, out_valid<=1, out_last<=0.
    - crc<=step(crc,in_data); byte_cnt saturates at MIN_FRAME_BYTES.
    - If in_last and byte_cnt+1 < MIN_FRAME_BYTES, go to PAD. Else if in_last, go to FCS with idx=0.
    - With no accepted byte and load_en, out_valid<=0.
  - PAD: on each load_en, emit 8'h00, crc<=step(crc,8'h00), byte_cnt++. When byte_cnt+1 == MIN_FRAME_BYTES, go to FCS with idx=0. in_ready=0.
  - FCS: f = ~crc (crc is frozen in this state).
    - On each load_en, emit f[8*idx+:8] and increment idx (2 bits).
    - At idx==3: out_last<=1, fcs_value<=f, return to PASS, crc<=FFFFFFFF, byte_cnt<=0. in_ready=0.
- frame_done is registered. It pulses the cycle after the out_last byte transfers.
- A new frame's first byte may be accepted in the same cycle the previous out_last byte transfers (PASS and load_en). No idle gap is required.
- Width rules:
  - crc is 32 bits, reflected polynomial 0xEDB88320.
  - Counter saturates at MIN_FRAME_BYTES and never wraps, so frames longer than 2^CNT_W bytes are legal.
- Edge cases:
  - Frame exactly MIN_FRAME_BYTES long: no PAD; FCS follows directly.
  - MIN_FRAME_BYTES=0: PAD is unreachable.
  - in_valid with in_ready=0 is ignored and must be held by the source.
  - out_ready low at any point stalls every state with no byte loss or duplication.

Decomposition:
- Shared package eth_pkg:
  - CRC32_INIT=32'hFFFFFFFF.
  - CRC32_RESIDUE=32'hDEBB20E3.
  - ETH_MIN_FRAME=60.
  - typedef enum logic[1:0] {FT_PASS, FT_PAD, FT_FCS} fcs_tx_state_t.
- One sub-module: the existing crc32_8bit combinational step, instanced once. Its input mux selects in_data in PASS and 8'h00 in PAD.

Test Plan:
- MIN_FRAME_BYTES=0, send ASCII "123456789" (31..39), out_ready=1 -> 9 bytes echoed, then 26 39 F4 CB with out_last on CB; fcs_value=32'hCBF43926; frame_done one cycle after.
- MIN=60, 1-byte frame 8'hAA -> exactly 64 output bytes: AA, 59×00, 4 FCS bytes. CRC run over all 64 outputs from init ends at CRC32_RESIDUE.
- MIN=60, 60-byte and 61-byte frames -> no pad bytes; totals are 64 and 65; residue check passes.
- Random out_ready (~50% duty) plus random in_valid gaps over 20 random frames -> output byte stream identical to a reference model, and out_* stable while stalled.
- Two back-to-back frames "123456789" -> second frame's first byte appears the cycle after the first frame's CB byte; both FCS = CBF43926.
- Assert reset during PAD of a short frame -> out_valid=0 immediately; the next frame "123456789" yields the correct FCS CBF43926.
